// File: rtl/y_intc_pkg.sv
// y_intc_pkg: shared definitions for the y_intc interrupt controller.
//   state_e    - controller state encoding (IDLE / FIRE / SERVICE)
//   NUM_IRQ    - number of interrupt request lines
//   VEC_STRIDE - byte spacing between handler entry points
//   vec_addr() - handler address for a line, modulo 2^32
package y_intc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FIRE    = 2'd1,
    SERVICE = 2'd2
  } state_e;

  localparam int unsigned NUM_IRQ    = 4;
  localparam int unsigned VEC_STRIDE = 16;

  // Carry out of bit 31 is dropped, so a base near the top of memory wraps.
  function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                           input logic [1:0]  id,
                                           input int unsigned stride);
    return base + (32'(id) * stride);
  endfunction

endpackage

// File: rtl/y_intc_prio.sv
// y_intc_prio: combinational 4-bit fixed-priority encoder.
//   req    [3:0] - candidate lines (pending & enable)
//   winner [1:0] - lowest-numbered set bit of req (0 when none)
//   any          - at least one bit of req is set
module y_intc_prio
  import y_intc_pkg::*;
(
  input  logic [3:0] req,
  output logic [1:0] winner,
  output logic       any
);

  always_comb begin
    winner = '0;
    any    = |req;
    if      (req[0]) winner = 2'd0;
    else if (req[1]) winner = 2'd1;
    else if (req[2]) winner = 2'd2;
    else if (req[3]) winner = 2'd3;
  end

endmodule

// File: rtl/y_intc.sv
// y_intc: edge-triggered, non-nesting interrupt controller.
//   clk        - clock, all state on rising edge
//   rst        - asynchronous active-high reset
//   irq        - request lines, rising-edge sensitive, synchronous to clk
//   enable     - per-line enable (1 = may fire)
//   vecBase    - vector table base address
//   retPC      - CPU PC+4, captured as the return address
//   eoi        - end-of-interrupt pulse
//   INT        - one-cycle interrupt strobe to the CPU
//   entryPoint - handler address of the accepted line
//   epc        - captured return address
//   activeId   - index of the line being serviced
//   busy       - high while in FIRE or SERVICE
module y_intc
  import y_intc_pkg::*;
#(
  parameter int unsigned NUM_IRQ    = y_intc_pkg::NUM_IRQ,
  parameter int unsigned VEC_STRIDE = y_intc_pkg::VEC_STRIDE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] enable,
  input  logic [31:0]        vecBase,
  input  logic [31:0]        retPC,
  input  logic               eoi,
  output logic               INT,
  output logic [31:0]        entryPoint,
  output logic [31:0]        epc,
  output logic [1:0]         activeId,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
  logic               int_q, int_d;
  logic [31:0]        entry_q, entry_d;
  logic [31:0]        epc_q, epc_d;
  logic [1:0]         active_q, active_d;
  logic               busy_q, busy_d;

  logic [NUM_IRQ-1:0] irq_rise;
  logic [NUM_IRQ-1:0] clr_mask;
  logic [1:0]         winner;
  logic               any;

  y_intc_prio u_prio (
    .req    (pending_q & enable),
    .winner (winner),
    .any    (any)
  );

  assign irq_rise = irq & ~irq_prev_q;

  always_comb begin
    state_d    = state_q;
    irq_prev_d = irq;
    int_d      = 1'b0;
    entry_d    = entry_q;
    epc_d      = epc_q;
    active_d   = active_q;
    clr_mask   = '0;

    case (state_q)
      IDLE: begin
        if (any) begin
          state_d          = FIRE;
          int_d            = 1'b1;
          active_d         = winner;
          entry_d          = vec_addr(vecBase, winner, VEC_STRIDE);
          epc_d            = retPC;
          clr_mask[winner] = 1'b1;
        end
      end
      FIRE:    state_d = SERVICE;
      SERVICE: if (eoi) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A new edge on the line being cleared keeps it pending.
    pending_d = (pending_q & ~clr_mask) | irq_rise;
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      irq_prev_q <= '1;
      int_q      <= 1'b0;
      entry_q    <= '0;
      epc_q      <= '0;
      active_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      irq_prev_q <= irq_prev_d;
      int_q      <= int_d;
      entry_q    <= entry_d;
      epc_q      <= epc_d;
      active_q   <= active_d;
      busy_q     <= busy_d;
    end
  end

  assign INT        = int_q;
  assign entryPoint = entry_q;
  assign epc        = epc_q;
  assign activeId   = active_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_y_intc.sv
module tb_y_intc;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq;
  logic [3:0]  enable;
  logic [31:0] vec_base;
  logic [31:0] ret_pc;
  logic        eoi;
  logic        int_s;
  logic [31:0] entry_point;
  logic [31:0] epc;
  logic [1:0]  active_id;
  logic        busy;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] ep;
    logic [31:0] pc;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  y_intc #(.NUM_IRQ(4), .VEC_STRIDE(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq        (irq),
    .enable     (enable),
    .vecBase    (vec_base),
    .retPC      (ret_pc),
    .eoi        (eoi),
    .INT        (int_s),
    .entryPoint (entry_point),
    .epc        (epc),
    .activeId   (active_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      #1;
    end
  endtask

  // INT is expected on the edge at cycle 'at'
  task automatic expect_int(input logic [1:0] id, input logic [31:0] ep, input logic [31:0] pc, input int at);
    exp_t e;
    e.id = id; e.ep = ep; e.pc = pc; e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask

  // Monitor: every INT cycle must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && int_s) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_int", 32'(int_s), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("int_cycle",  32'(cyc), 32'(e.cyc));
        chk("activeId",   32'(active_id), 32'(e.id));
        chk("entryPoint", entry_point, e.ep);
        chk("epc",        epc, e.pc);
        chk("busy_in_fire", 32'(busy), 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; irq = '0; enable = 4'hF; vec_base = 32'h0000_1000;
    ret_pc = 32'h40; eoi = 1'b0;
    tick(2);
    chk("rst_int",   32'(int_s), 0);
    chk("rst_entry", entry_point, 0);
    chk("rst_epc",   epc, 0);
    chk("rst_id",    32'(active_id), 0);
    chk("rst_busy",  32'(busy), 0);
    rst = 1'b0;
    tick();

    // single irq on line 2; eoi held through IDLE and FIRE must be ignored
    irq = 4'b0100;
    expect_int(2'd2, 32'h1020, 32'h40, cyc + 2);
    tick();
    eoi = 1'b1;
    tick(2);
    eoi = 1'b0;
    ret_pc = 32'h80;
    chk("busy_service", 32'(busy), 1);
    tick();
    chk("hold_entry", entry_point, 32'h1020);
    chk("hold_epc",   epc, 32'h40);
    chk("hold_id",    32'(active_id), 2);
    pulse_eoi();
    chk("busy_after_eoi", 32'(busy), 0);
    irq = '0;
    tick();

    // priority: lines 3 and 1 together, line 1 first, line 3 after eoi
    ret_pc = 32'h44;
    irq = 4'b1010;
    expect_int(2'd1, 32'h1010, 32'h44, cyc + 2);
    expect_int(2'd3, 32'h1030, 32'h44, cyc + 5);
    tick(3);
    pulse_eoi();
    tick(2);
    pulse_eoi();
    irq = '0;
    tick();

    // masked line stays pending, fires once enabled
    enable = 4'b1110;
    irq = 4'b0001;
    tick(4);
    chk("masked_busy", 32'(busy), 0);
    enable = 4'hF;
    expect_int(2'd0, 32'h1000, 32'h44, cyc + 1);
    tick(2);
    pulse_eoi();
    irq = '0;
    tick();

    // vector address wraps modulo 2^32
    vec_base = 32'hFFFF_FFF0;
    irq = 4'b0010;
    expect_int(2'd1, 32'h0000_0000, 32'h44, cyc + 2);
    tick(3);
    pulse_eoi();
    irq = '0;
    vec_base = 32'h0000_1000;
    tick();

    // re-edge on line 2 during its FIRE cycle -> second INT for line 2
    irq = 4'b0100;
    expect_int(2'd2, 32'h1020, 32'h44, cyc + 2);
    expect_int(2'd2, 32'h1020, 32'h44, cyc + 5);
    tick();
    irq = 4'b0000;
    tick();
    irq = 4'b0100;
    tick();
    pulse_eoi();
    tick(2);
    pulse_eoi();
    irq = '0;
    tick();

    // reset mid-service with irq[0] held high and line 3 pending
    irq = 4'b0001;
    expect_int(2'd0, 32'h1000, 32'h44, cyc + 2);
    tick();
    irq = 4'b1001;
    tick(2);
    chk("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("async_int",   32'(int_s), 0);
    chk("async_entry", entry_point, 0);
    chk("async_epc",   epc, 0);
    chk("async_id",    32'(active_id), 0);
    chk("async_busy",  32'(busy), 0);
    tick(2);
    rst = 1'b0;
    tick(6);
    chk("post_rst_busy", 32'(busy), 0);
    irq = 4'b0000;
    tick();
    irq = 4'b0001;
    expect_int(2'd0, 32'h1000, 32'h44, cyc + 2);
    tick(3);
    pulse_eoi();
    irq = '0;
    tick(3);

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
